// File: rtl/riscv_v_issue_queue.sv
// riscv_v_issue_queue
//   Small circular-buffer FIFO that sits between the scalar core and the
//   vector decode stage. Each entry holds a vector instruction together with
//   the scalar rs1 operand captured at push time. The head entry is presented
//   to vector decode every cycle. When the queue is empty, the output is a
//   NOP with zero data.
//
// Parameters
//   DEPTH      number of entries (power of two, >= 2)
//   NOP_INSTR  instruction presented to decode when nothing valid is queued
//
// Ports
//   clk               clock
//   rst               synchronous active-high reset
//   clear_pipe        flush: discards every entry, blocks pushes this cycle
//   push_valid        scalar core offers an instruction
//   push_instr        offered instruction
//   push_rs1_data     scalar operand travelling with the instruction
//   push_ready        queue accepts a push this cycle
//   riscv_v_stall     vector decode cannot consume the head this cycle
//   instruction_id    head instruction (NOP_INSTR when invalid)
//   int_rf_rd_data_id head scalar operand (0 when invalid)
//   instr_valid_id    head is a real instruction
//   occupancy         number of valid entries
//   overflow_err      sticky: a push was offered while push_ready was low
//
// Configuration macro
//   RISCV_V_ISSUE_QUEUE_BYPASS_EN  when defined, a push into an empty queue
//   is forwarded to decode in the same cycle. If decode does not stall, the
//   instruction is consumed without occupying storage.

module riscv_v_issue_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_pipe,
  input  logic                     push_valid,
  input  logic [31:0]              push_instr,
  input  logic [31:0]              push_rs1_data,
  output logic                     push_ready,
  input  logic                     riscv_v_stall,
  output logic [31:0]              instruction_id,
  output logic [31:0]              int_rf_rd_data_id,
  output logic                     instr_valid_id,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          ovf_q;

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   data_mem_q  [DEPTH];

  logic          has_entry;
  logic          bypass_hit;
  logic          push;
  logic          pop;

  // Head selection and handshake. In the bypass build, an empty queue
  // forwards the offered instruction directly. An empty queue always
  // accepts a push unless a flush is in progress, so push_ready never
  // feeds back into this term.
  always_comb begin
    has_entry = (state_q != EMPTY);
`ifdef RISCV_V_ISSUE_QUEUE_BYPASS_EN
    bypass_hit = (state_q == EMPTY) && push_valid && !clear_pipe;
`else
    bypass_hit = 1'b0;
`endif
    instr_valid_id = has_entry || bypass_hit;
    pop            = instr_valid_id && !riscv_v_stall;
    // A full queue still accepts a push in a cycle where the head leaves.
    push_ready     = !clear_pipe && ((state_q != FULL) || pop);
    push           = push_valid && push_ready;

    if (has_entry) begin
      instruction_id    = instr_mem_q[rd_ptr_q];
      int_rf_rd_data_id = data_mem_q[rd_ptr_q];
    end else if (bypass_hit) begin
      instruction_id    = push_instr;
      int_rf_rd_data_id = push_rs1_data;
    end else begin
      instruction_id    = NOP_INSTR;
      int_rf_rd_data_id = 32'h0;
    end
  end

  // Pointer and count bookkeeping. A bypassed instruction advances both
  // pointers together, so the count is unchanged and the slot is simply
  // skipped. DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + CW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - CW'(1);
    end
    if (occ_d == '0) begin
      state_d = EMPTY;
    end else if (occ_d == FULL_CNT) begin
      state_d = FULL;
    end else begin
      state_d = PARTIAL;
    end
  end

  // Control state. Reset beats flush, and flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else if (clear_pipe) begin
      state_q  <= EMPTY;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      if (push_valid && !push_ready) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Entry storage has no reset. Stale contents are never visible because
  // the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= push_instr;
      data_mem_q[wr_ptr_q]  <= push_rs1_data;
    end
  end

  assign occupancy    = occ_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_riscv_v_issue_queue.sv
// Testbench for riscv_v_issue_queue.
// A queue-based reference model tracks the expected contents. A compare
// process checks every output on each falling edge. Directed scenarios
// add literal expectations at key points.

module tb_riscv_v_issue_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_pipe = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_instr = 32'h0;
  logic [31:0] push_rs1_data = 32'h0;
  logic        riscv_v_stall = 1'b0;
  logic        push_ready;
  logic [31:0] instruction_id;
  logic [31:0] int_rf_rd_data_id;
  logic        instr_valid_id;
  logic [2:0]  occupancy;
  logic        overflow_err;

  int total = 0;
  int bad = 0;
  logic checkEn = 1'b0;

  logic [63:0] modelQ [$];
  logic        modelOvf = 1'b0;

  riscv_v_issue_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .clear_pipe(clear_pipe),
    .push_valid(push_valid),
    .push_instr(push_instr),
    .push_rs1_data(push_rs1_data),
    .push_ready(push_ready),
    .riscv_v_stall(riscv_v_stall),
    .instruction_id(instruction_id),
    .int_rf_rd_data_id(int_rf_rd_data_id),
    .instr_valid_id(instr_valid_id),
    .occupancy(occupancy),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // The head is valid whenever something is queued. In the bypass build,
  // an offered push into an empty queue is also visible immediately.
  function automatic logic modelValid();
`ifdef RISCV_V_ISSUE_QUEUE_BYPASS_EN
    return (modelQ.size() != 0) || (push_valid && !clear_pipe);
`else
    return (modelQ.size() != 0);
`endif
  endfunction

  function automatic logic modelReady();
    return !clear_pipe && ((modelQ.size() < DEPTH) || (modelValid() && !riscv_v_stall));
  endfunction

  function automatic logic [63:0] modelHead();
    if (modelQ.size() != 0) return modelQ[0];
    if (modelValid()) return {push_instr, push_rs1_data};
    return {NOP, 32'h0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Reference model update. Inputs are still stable at the rising edge.
  always @(posedge clk) begin
    logic v, r;
    if (rst) begin
      modelQ.delete();
      modelOvf = 1'b0;
      checkEn  = 1'b1;
    end else if (clear_pipe) begin
      modelQ.delete();
    end else begin
      v = modelValid();
      r = modelReady();
      if (push_valid && !r) modelOvf = 1'b1;
      if (push_valid && r) modelQ.push_back({push_instr, push_rs1_data});
      if (v && !riscv_v_stall) void'(modelQ.pop_front());
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [63:0] head;
    if (checkEn) begin
      head = modelHead();
      checkOutput("m_valid", {31'b0, instr_valid_id}, {31'b0, modelValid()});
      checkOutput("m_instr", instruction_id, head[63:32]);
      checkOutput("m_data", int_rf_rd_data_id, head[31:0]);
      checkOutput("m_occ", 32'(occupancy), 32'(modelQ.size()));
      checkOutput("m_ready", {31'b0, push_ready}, {31'b0, modelReady()});
      checkOutput("m_ovf", {31'b0, overflow_err}, {31'b0, modelOvf});
    end
  end

  task automatic applyStimulus(input logic r, input logic c, input logic pv, input logic st,
                               input logic [31:0] ins, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst           = r;
    clear_pipe    = c;
    push_valid    = pv;
    riscv_v_stall = st;
    push_instr    = ins;
    push_rs1_data = d;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, {31'b0, instr_valid_id}, 32'd0);
    checkOutput({tag, "_instr"}, instruction_id, 32'h0000_0013);
    checkOutput({tag, "_data"}, int_rf_rd_data_id, 32'h0);
    checkOutput({tag, "_occ"}, 32'(occupancy), 32'd0);
    checkOutput({tag, "_ready"}, {31'b0, push_ready}, 32'd1);
    checkOutput({tag, "_ovf"}, {31'b0, overflow_err}, 32'd0);
  endtask

  initial begin
    // Reset.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkResetOutputs("rst");

    // Single push with no stall.
    applyStimulus(0, 0, 1, 0, 32'hAAAA_0057, 32'h11);
`ifdef RISCV_V_ISSUE_QUEUE_BYPASS_EN
    @(negedge clk);
    checkOutput("byp_instr", instruction_id, 32'hAAAA_0057);
    checkOutput("byp_data", int_rf_rd_data_id, 32'h11);
    applyStimulus(0, 0, 0, 0, 0, 0);
`else
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("one_valid", {31'b0, instr_valid_id}, 32'd1);
    checkOutput("one_instr", instruction_id, 32'hAAAA_0057);
    checkOutput("one_data", int_rf_rd_data_id, 32'h11);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("one_nop", instruction_id, 32'h0000_0013);
    checkOutput("one_occ", 32'(occupancy), 32'd0);

    // Fill under stall, overflow, then drain in order.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 32'hA000_0057 + (i << 8), i);
    applyStimulus(0, 0, 1, 1, 32'hEEEE_0057, 32'h5);
    @(negedge clk);
    checkOutput("full_occ", 32'(occupancy), 32'd4);
    checkOutput("full_ready", {31'b0, push_ready}, 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("ovf_set", {31'b0, overflow_err}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("drain_order", instruction_id, 32'hA000_0057 + (i << 8));
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("drain_empty", {31'b0, instr_valid_id}, 32'd0);

    // Push into a full queue while popping.
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 32'hF000_0057 + (i << 8), i);
    applyStimulus(0, 0, 1, 0, 32'hE000_0057, 32'h77);
    @(negedge clk);
    checkOutput("pp_ready", {31'b0, push_ready}, 32'd1);
    checkOutput("pp_head", instruction_id, 32'hF000_0057);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (i == 1) checkOutput("pp_occ", 32'(occupancy), 32'd4);
      checkOutput("pp_order", instruction_id, 32'hF000_0057 + (i << 8));
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pp_tail", instruction_id, 32'hE000_0057);
    checkOutput("pp_ovf", {31'b0, overflow_err}, 32'd0);

    // Flush with a concurrent push.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 32'hC000_0057 + i, i);
    applyStimulus(0, 1, 1, 1, 32'hDEAD_0057, 32'h99);
    @(negedge clk);
    checkOutput("clr_ready", {31'b0, push_ready}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("clr_occ", 32'(occupancy), 32'd0);
    checkOutput("clr_valid", {31'b0, instr_valid_id}, 32'd0);
    checkOutput("clr_instr", instruction_id, 32'h0000_0013);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // Random stall stream across the pointer wrap.
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 0, 1, 1'($urandom_range(0, 1)), 32'hB000_0000 + i, i * 3);
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a stream.
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 0, 1, 1'($urandom_range(0, 1)), 32'h9000_0000 + i, i);
    applyStimulus(1, 0, 1, 0, 32'h8888_0057, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkResetOutputs("midrst");
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_v_issue_queue.md
RISCV_V_ISSUE_QUEUE -- requirements
Module: riscv_v_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >= 2).
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, instruction driven to decode when no entry is valid.
REQ-003 SHALL have one clock and a synchronous active-high reset, clk and rst, with no other clock or reset.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 clear_pipe  input  1  flush request; discards all entries.
REQ-007 push_valid  input  1  scalar core offers a vector instruction.
REQ-008 push_instr  input  riscv_instruction_t  offered instruction.
REQ-009 push_rs1_data  input  riscv_data_t  scalar operand captured with the instruction.
REQ-010 push_ready  output  1  queue accepts a push this cycle.
REQ-011 riscv_v_stall  input  1  vector decode cannot consume this cycle.
REQ-012 instruction_id  output  riscv_instruction_t  head instruction to vector decode.
REQ-013 int_rf_rd_data_id  output  riscv_data_t  head scalar operand.
REQ-014 instr_valid_id  output  1  instruction_id holds a real queued instruction.
REQ-015 occupancy  output  $clog2(DEPTH)+1  number of valid entries.
REQ-016 overflow_err  output  1  sticky; push_valid seen while push_ready low.

Function
REQ-017 Push SHALL occur when push_valid && push_ready; pop SHALL occur when instr_valid_id && !riscv_v_stall.
REQ-018 push_ready SHALL equal (occupancy != DEPTH) || pop, allowing push into a full queue in a popping cycle.
REQ-019 Entries SHALL be stored in a circular buffer with read/write pointers wrapping from DEPTH-1 to 0.
REQ-020 Head SHALL be registered-output FIFO order; pushed instruction SHALL appear on instruction_id no earlier than the next cycle (without bypass, see Configuration).
REQ-021 When instr_valid_id is 0, instruction_id SHALL equal NOP_INSTR and int_rf_rd_data_id SHALL be 0.
REQ-022 Control FSM states: EMPTY (occupancy 0), PARTIAL (0<occ<DEPTH), FULL (occ=DEPTH); transitions purely by push/pop per cycle.
REQ-023 EMPTY->PARTIAL on push; PARTIAL->FULL on push-only at occ=DEPTH-1; FULL->PARTIAL on pop-only; PARTIAL->EMPTY on pop-only at occ=1; simultaneous push and pop SHALL hold state and occupancy.
REQ-024 Pop SHALL be ignored in EMPTY; riscv_v_stall high SHALL freeze head and occupancy except for push.
REQ-025 clear_pipe SHALL, next cycle, set occupancy 0, pointers 0, state EMPTY; a push in the same cycle as clear_pipe SHALL be dropped; push_ready SHALL be 0 while clear_pipe is high.
REQ-026 overflow_err SHALL set on push_valid && !push_ready && !clear_pipe and hold until reset.

Reset
REQ-027 On rst: occupancy 0, pointers 0, state EMPTY, instr_valid_id 0, instruction_id NOP_INSTR, int_rf_rd_data_id 0, overflow_err 0, push_ready 1 the cycle after rst deasserts.
REQ-028 rst SHALL dominate clear_pipe, push and pop in the same cycle; reset mid-operation SHALL discard all entries.

Configuration
REQ-029 Macro RISCV_V_ISSUE_QUEUE_BYPASS_EN SHALL control empty-queue bypass.
REQ-030 With RISCV_V_ISSUE_QUEUE_BYPASS_EN defined: in EMPTY, push data SHALL drive instruction_id/int_rf_rd_data_id combinationally with instr_valid_id 1 in the push cycle; if not stalled it is consumed without entering storage.
REQ-031 Without it: minimum push-to-instr_valid_id latency SHALL be exactly one cycle in all states.

Verification
REQ-032 Reset, push 0xAAAA_0057 with rs1 0x11, stall 0 -> next cycle instr_valid_id 1, instruction_id 0xAAAA_0057, int_rf_rd_data_id 0x11 (same cycle if bypass enabled); then NOP_INSTR, occupancy 0.
REQ-033 Stall held, push 4 instrs A,B,C,D -> occupancy 4, push_ready 0; 5th push -> overflow_err 1; release stall -> A,B,C,D pop in order over 4 cycles.
REQ-034 FULL with stall 0, simultaneous push E and pop -> occupancy stays 4, E emerges after D, no overflow_err.
REQ-035 Occupancy 3, clear_pipe with concurrent push -> next cycle occupancy 0, instr_valid_id 0, instruction_id 0x0000_0013, pushed instr never issued.
REQ-036 Push 10 instrs with random stall -> order preserved across pointer wrap; rst asserted mid-stream -> all outputs at reset values next cycle.
